// File: rtl/cpu_run_ctrl_pkg.sv
// Shared state encoding and default parameters
// for the boot-and-run sequencer.
package cpu_run_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_RELEASE = 3'd2,
      S_RUN     = 3'd3,
      S_DONE    = 3'd4
   } run_state_t;

   localparam int XLEN_DEF        = 32;
   localparam int IMEM_AW_DEF     = 10;
   localparam int RELEASE_DLY_DEF = 2;
   localparam int CNT_W_DEF       = 32;
   localparam int TIMEOUT_DEF     = 0;

endpackage

// File: rtl/cpu_run_ctrl_counter.sv
// Saturating up-counter with synchronous clear
// and a terminal-count compare.
module run_counter
   import cpu_run_ctrl_pkg::*;
#(
   parameter int W = CNT_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] term,
   output logic [W-1:0] cnt,
   output logic         at_term
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign at_term = (cnt == term);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Boot-and-run sequencer: loads imem, releases
// core reset, then runs free or single-step.
module cpu_run_ctrl
   import cpu_run_ctrl_pkg::*;
#(
   parameter int XLEN        = XLEN_DEF,
   parameter int IMEM_AW     = IMEM_AW_DEF,
   parameter int RELEASE_DLY = RELEASE_DLY_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int TIMEOUT     = TIMEOUT_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               ld_valid,
   output logic               ld_ready,
   input  logic [XLEN-1:0]    ld_data,
   input  logic               ld_last,
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [XLEN-1:0]    imem_wdata,
   output logic               core_rst,
   output logic               core_pc_en,
   input  logic               step_mode,
   input  logic               step,
   input  logic               halt_in,
   output logic               busy,
   output logic               done,
   output logic               timed_out,
   output logic               load_ovf,
   output logic [CNT_W-1:0]   cycle_cnt
);

   localparam logic [CNT_W-1:0] DLY_TERM =
      CNT_W'(RELEASE_DLY > 0 ? RELEASE_DLY - 1 : 0);
   localparam logic [CNT_W-1:0] TO_TERM =
      CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

   run_state_t         state;
   logic [IMEM_AW-1:0] addr;
   logic               hs;
   logic               at_top;
   logic               load_end;
   logic               grant;
   logic               pc_cyc;
   logic               to_hit;
   logic               go_load;
   logic               cyc_clr;
   logic               cyc_at_term;
   logic               dly_clr;
   logic               dly_en;
   logic               dly_at_term;
   logic [CNT_W-1:0]   dly_cnt_unused;

   assign hs       = ld_valid & ld_ready;
   assign at_top   = &addr;
   assign load_end = hs & (ld_last | at_top);
   assign grant    = ~step_mode | step;
   assign pc_cyc   = (state == S_RUN) & core_pc_en;
   assign to_hit   = (TIMEOUT != 0) & pc_cyc
                   & cyc_at_term;
   assign go_load  = start
                   & ((state == S_IDLE)
                   | (state == S_DONE));

   assign imem_we    = hs;
   assign imem_addr  = addr;
   assign imem_wdata = ld_data;

   // cycle_cnt restarts on a new load and on
   // leaving LOAD, so DONE holds the final count
   assign cyc_clr = go_load
                  | ((state == S_LOAD) & load_end);
   assign dly_clr = (state == S_LOAD) & load_end;
   assign dly_en  = (state == S_RELEASE);

   run_counter #(.W(CNT_W)) u_cyc (
      .clk     (clk),
      .rst     (rst),
      .clr     (cyc_clr),
      .en      (pc_cyc),
      .term    (TO_TERM),
      .cnt     (cycle_cnt),
      .at_term (cyc_at_term)
   );

   run_counter #(.W(CNT_W)) u_dly (
      .clk     (clk),
      .rst     (rst),
      .clr     (dly_clr),
      .en      (dly_en),
      .term    (DLY_TERM),
      .cnt     (dly_cnt_unused),
      .at_term (dly_at_term)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         addr       <= '0;
         core_rst   <= 1'b1;
         core_pc_en <= 1'b0;
         ld_ready   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         timed_out  <= 1'b0;
         load_ovf   <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state     <= S_LOAD;
                  addr      <= '0;
                  core_rst  <= 1'b1;
                  ld_ready  <= 1'b1;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  timed_out <= 1'b0;
                  load_ovf  <= 1'b0;
               end
            end
            S_LOAD: begin
               if (hs) begin
                  if (!at_top) addr <= addr + 1'b1;
                  // last slot filled without ld_last
                  // ends the load rather than wrapping
                  if (ld_last || at_top) begin
                     load_ovf <= ~ld_last;
                     ld_ready <= 1'b0;
                     core_rst <= 1'b0;
                     if (RELEASE_DLY == 0) begin
                        state      <= S_RUN;
                        core_pc_en <= grant;
                     end else begin
                        state <= S_RELEASE;
                     end
                  end
               end
            end
            S_RELEASE: begin
               if (dly_at_term) begin
                  state      <= S_RUN;
                  core_pc_en <= grant;
               end
            end
            S_RUN: begin
               if (halt_in || to_hit) begin
                  state      <= S_DONE;
                  core_pc_en <= 1'b0;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  timed_out  <= ~halt_in;
               end else begin
                  core_pc_en <= grant;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed
// table, corner sequences, random scenarios.
module tb_cpu_run_ctrl;

   localparam int AW  = 2;
   localparam int DLY = 2;
   localparam int TO  = 10;
   localparam int SW  = 3;
   localparam int SAT = 7;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        ld_valid = 1'b0;
   logic        ld_last = 1'b0;
   logic        step_mode = 1'b0;
   logic        step = 1'b0;
   logic        halt_in = 1'b0;
   logic [31:0] ld_data = '0;

   logic          ld_ready, imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_rst, core_pc_en, busy;
   logic          done, timed_out, load_ovf;
   logic [31:0]   cycle_cnt;

   logic          s_ld_ready, s_imem_we;
   logic [AW-1:0] s_imem_addr;
   logic [31:0]   s_imem_wdata;
   logic          s_core_rst, s_core_pc_en, s_busy;
   logic          s_done, s_timed_out, s_load_ovf;
   logic [SW-1:0] s_cycle_cnt;

   cpu_run_ctrl #(
      .XLEN(32), .IMEM_AW(AW), .RELEASE_DLY(DLY),
      .CNT_W(32), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_data(ld_data), .ld_last(ld_last),
      .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .core_rst(core_rst),
      .core_pc_en(core_pc_en), .step_mode(step_mode),
      .step(step), .halt_in(halt_in), .busy(busy),
      .done(done), .timed_out(timed_out),
      .load_ovf(load_ovf), .cycle_cnt(cycle_cnt)
   );

   // narrow counter, no timeout: saturation check
   cpu_run_ctrl #(
      .XLEN(32), .IMEM_AW(AW), .RELEASE_DLY(DLY),
      .CNT_W(SW), .TIMEOUT(0)
   ) u_sat (
      .clk(clk), .rst(rst), .start(start),
      .ld_valid(ld_valid), .ld_ready(s_ld_ready),
      .ld_data(ld_data), .ld_last(ld_last),
      .imem_we(s_imem_we), .imem_addr(s_imem_addr),
      .imem_wdata(s_imem_wdata),
      .core_rst(s_core_rst),
      .core_pc_en(s_core_pc_en),
      .step_mode(step_mode), .step(step),
      .halt_in(halt_in), .busy(s_busy),
      .done(s_done), .timed_out(s_timed_out),
      .load_ovf(s_load_ovf), .cycle_cnt(s_cycle_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int nw; int last; int sm; int h;
      int ecnt; int eto; int eovf; int ewr;
   } vec_t;

   vec_t        tbl [9];
   logic [31:0] prog [5];
   int          wa [$];
   logic [31:0] wd [$];
   int          vecs = 0;
   int          errs = 0;

   always @(negedge clk) begin
      #2;
      if (imem_we === 1'b1) begin
         wa.push_back(int'(imem_addr));
         wd.push_back(imem_wdata);
      end
   end

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
      end
   endtask

   task automatic do_load(input int nw,
                          input int last,
                          input int eovf,
                          output int since);
      int i = 0;
      int guard = 0;
      bit v;
      wa.delete();
      wd.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ld_ready_rise", ld_ready, 1);
      chk("load_core_rst", core_rst, 1);
      chk("load_busy", busy, 1);
      chk("load_done_clr", done, 0);
      chk("load_cnt_clr", cycle_cnt, 0);
      chk("load_to_clr", timed_out, 0);
      chk("load_ovf_clr", load_ovf, 0);
      chk("load_addr0", imem_addr, 0);
      while (i < nw && guard < 100) begin
         if (ld_ready !== 1'b1) break;
         v = ($urandom_range(0, 3) != 0);
         ld_valid = v;
         ld_data  = prog[i];
         ld_last  = (last != 0) && (i == nw - 1);
         @(negedge clk);
         guard++;
         if (v) i++;
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      chk("load_guard", guard < 100, 1);
      chk("rst_fall", core_rst, 0);
      chk("ld_ready_drop", ld_ready, 0);
      chk("load_ovf", load_ovf, eovf);
      since = 1;
      if (i < nw) begin
         ld_valid = 1'b1;
         ld_data  = prog[i];
         ld_last  = (last != 0) && (i == nw - 1);
         @(negedge clk);
         ld_valid = 1'b0;
         ld_last  = 1'b0;
         since = 2;
      end
   endtask

   task automatic do_run(input int h,
                         input int since,
                         output int n,
                         output int first_idx,
                         output int last_idx,
                         output int done_idx);
      int idx = since;
      n = 0;
      first_idx = -1;
      last_idx = -1;
      done_idx = -1;
      for (int g = 0; g < 400; g++) begin
         if (done === 1'b1) begin
            done_idx = idx;
            break;
         end
         if (core_pc_en === 1'b1) begin
            n++;
            last_idx = idx;
            if (first_idx < 0) first_idx = idx;
         end
         halt_in = (core_pc_en === 1'b1)
                   && (h > 0) && (n == h);
         step = step_mode ?
                1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
         idx++;
      end
      halt_in = 1'b0;
      step = 1'b0;
   endtask

   task automatic scenario(input vec_t v);
      int since, n, fi, li, di, sexp;
      step_mode = v.sm[0];
      step = 1'b0;
      do_load(v.nw, v.last, v.eovf, since);
      do_run(v.h, since, n, fi, li, di);
      chk("run_done", done, 1);
      chk("pc_en_cycles", n, v.ecnt);
      chk("cycle_cnt", cycle_cnt, v.ecnt);
      chk("timed_out", timed_out, v.eto);
      chk("done_pc_en", core_pc_en, 0);
      chk("done_core_rst", core_rst, 0);
      chk("done_busy", busy, 0);
      chk("ovf_held", load_ovf, v.eovf);
      chk("done_latency", di, li + 1);
      if (v.sm == 0) chk("release_dly", fi, DLY + 1);
      sexp = (v.ecnt > SAT) ? SAT : v.ecnt;
      chk("sat_cnt", s_cycle_cnt, sexp);
      chk("sat_done", s_done, v.eto == 0);
      chk("sat_to", s_timed_out, 0);
      chk("wr_count", wa.size(), v.ewr);
      for (int k = 0; k < wa.size() && k < 5; k++) begin
         chk("wr_addr", wa[k], k);
         chk("wr_data", wd[k], prog[k]);
      end
      halt_in = 1'b1;
      @(negedge clk);
      halt_in = 1'b0;
      chk("cnt_held", cycle_cnt, v.ecnt);
      chk("done_held", done, 1);
      chk("sat_sync", s_done, 1);
   endtask

   function automatic vec_t model(int nw, int last,
                                  int sm, int h);
      vec_t r;
      bit   to;
      to = (h == 0) || (h > TO);
      r.nw   = nw;
      r.last = last;
      r.sm   = sm;
      r.h    = h;
      r.ecnt = to ? TO : h;
      r.eto  = to ? 1 : 0;
      r.eovf = (last != 0 && nw <= (1 << AW)) ? 0 : 1;
      r.ewr  = (nw > (1 << AW)) ? (1 << AW) : nw;
      return r;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: time limit hit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic pat [12];
      int k;
      int since;
      int nw, last;
      pat = '{1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0};

      tbl[0] = '{4, 1, 0, 4,  4,  0, 0, 4};
      tbl[1] = '{4, 1, 0, 0,  10, 1, 0, 4};
      tbl[2] = '{4, 1, 0, 10, 10, 0, 0, 4};
      tbl[3] = '{4, 1, 0, 11, 10, 1, 0, 4};
      tbl[4] = '{5, 0, 0, 2,  2,  0, 1, 4};
      tbl[5] = '{4, 0, 0, 3,  3,  0, 1, 4};
      tbl[6] = '{5, 1, 0, 5,  5,  0, 1, 4};
      tbl[7] = '{2, 1, 0, 1,  1,  0, 0, 2};
      tbl[8] = '{1, 1, 1, 3,  3,  0, 0, 1};

      repeat (2) @(negedge clk);
      chk("rst_core_rst", core_rst, 1);
      chk("rst_pc_en", core_pc_en, 0);
      chk("rst_ld_ready", ld_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_to", timed_out, 0);
      chk("rst_ovf", load_ovf, 0);
      chk("rst_cnt", cycle_cnt, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_we", imem_we, 0);
      chk("sat_reset",
          {s_ld_ready, s_imem_we, s_core_rst,
           s_core_pc_en, s_busy, s_done,
           s_timed_out, s_load_ovf,
           s_cycle_cnt, s_imem_addr},
          {8'b0010_0000, 3'd0, 2'd0});
      chk("sat_wdata", s_imem_wdata, ld_data);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_hold", {busy, core_rst}, 2'b01);

      prog[0] = 32'h0050_0093;
      prog[1] = 32'h0030_0113;
      prog[2] = 32'h0020_81B3;
      prog[3] = 32'h0000_0073;
      prog[4] = 32'hDEAD_BEEF;

      for (int i = 0; i < 9; i++) scenario(tbl[i]);

      // single-step: three isolated pulses
      step_mode = 1'b1;
      step = 1'b0;
      do_load(4, 1, 0, since);
      k = 0;
      repeat (6) begin
         @(negedge clk);
         if (core_pc_en === 1'b1) k++;
      end
      chk("step_quiet", k, 0);
      for (int c = 0; c < 12; c++) begin
         step = pat[c];
         @(negedge clk);
         chk("step_pulse", core_pc_en, pat[c]);
         if (core_pc_en === 1'b1) k++;
      end
      step = 1'b0;
      chk("step_count", k, 3);
      chk("step_cnt", cycle_cnt, 3);
      halt_in = 1'b1;
      @(negedge clk);
      halt_in = 1'b0;
      chk("step_done", done, 1);
      chk("step_done_cnt", cycle_cnt, 3);
      chk("step_done_to", timed_out, 0);
      step_mode = 1'b0;

      // reset asserted in the middle of a run
      do_load(4, 1, 0, since);
      k = 0;
      for (int g = 0; g < 20 && k < 3; g++) begin
         @(negedge clk);
         if (core_pc_en === 1'b1) k++;
      end
      chk("mid_run_reach", k, 3);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("mr_core_rst", core_rst, 1);
      chk("mr_pc_en", core_pc_en, 0);
      chk("mr_status",
          {busy, done, timed_out, load_ovf, ld_ready},
          5'b0);
      chk("mr_cnt", cycle_cnt, 0);
      chk("mr_addr", imem_addr, 0);
      @(negedge clk);
      chk("mr_idle", {busy, core_rst, core_pc_en},
          3'b010);

      for (int r = 0; r < 20; r++) begin
         for (int w = 0; w < 5; w++)
            prog[w] = $urandom;
         nw   = $urandom_range(1, 5);
         last = (nw < 4) ? 1 : $urandom_range(0, 1);
         scenario(model(nw, last,
                        $urandom_range(0, 1),
                        $urandom_range(0, 13)));
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vecs, errs);
      $finish;
   end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Synthesizable boot-and-run sequencer for the single-cycle RV32I core. It streams a program into instruction memory and holds the core in reset. It then releases reset, waits a programmed number of cycles, and enables the PC. Once running it counts executed cycles and supports free-run and single-step modes, stopping on a core halt or a cycle timeout. It replaces simulation-only `$readmem` loading and fixed reset/`pc_en` delays with parametrised hardware sequencing between a host loader and the core.

## Interface
Parameters:
- XLEN, 32: instruction/load word width.
- IMEM_AW, 10: instruction-memory word-address width (depth 2^IMEM_AW).
- RELEASE_DLY, 2: cycles between core reset release and first `core_pc_en`; 0 allowed.
- CNT_W, 32: cycle-counter width.
- TIMEOUT, 0: maximum run cycles; 0 disables the timeout.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; **synchronous, active-low** (resets when rst==0 at a rising edge).
- start  in  1  level; sampled in IDLE/DONE to begin a load.
- ld_valid  in  1  load word valid.
- ld_ready  out  1  load word accepted when valid&ready.
- ld_data  in  XLEN  load word.
- ld_last  in  1  marks final word of program.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  IMEM_AW  word address.
- imem_wdata  out  XLEN  write data.
- core_rst  out  1  active-high reset to core.
- core_pc_en  out  1  PC enable to core.
- step_mode  in  1  1 = single-step, 0 = free-run.
- step  in  1  in step mode, each cycle high grants one pc_en cycle.
- halt_in  in  1  core retired ECALL/EBREAK.
- busy  out  1  state not IDLE/DONE.
- done  out  1  in DONE.
- timed_out  out  1  DONE reached by timeout.
- load_ovf  out  1  load ran past last address.
- cycle_cnt  out  CNT_W  cycles with core_pc_en=1 in current run.

## Operation
- States: IDLE, LOAD, RELEASE, RUN, DONE.
- Reset values: state=IDLE, core_rst=1, core_pc_en=0, ld_ready=0, busy=0, done=0, timed_out=0, load_ovf=0, cycle_cnt=0, imem_addr=0.
- IDLE: core_rst=1. start=1 → LOAD, address cleared.
- LOAD: core_rst=1, ld_ready=1. Handshake (valid&ready) writes ld_data at imem_addr, then the address increments.
  - ld_last accepted → RELEASE.
  - Handshake at address 2^IMEM_AW-1 without ld_last: the word is written, load_ovf=1, → RELEASE. No wrap.
- RELEASE: core_rst=0, core_pc_en=0 for RELEASE_DLY cycles, then → RUN. cycle_cnt cleared on entry.
- RUN: core_rst=0.
  - Free-run: core_pc_en=1.
  - Step mode: core_pc_en=step. step_mode may change at any cycle and takes effect on the next core_pc_en.
  - cycle_cnt increments on each pc_en cycle and saturates at all-ones.
- Exit from RUN:
  - halt_in=1 → DONE.
  - TIMEOUT≠0 and a pc_en cycle with cycle_cnt==TIMEOUT-1 → DONE with timed_out=1.
  - halt and timeout in the same cycle → DONE, timed_out=0 (halt wins).
- DONE: core_pc_en=0, core_rst=0 so core state remains inspectable, done=1, cycle_cnt held. start=1 → LOAD; core_rst reasserts, and timed_out, load_ovf and cycle_cnt clear.
- rst=0 in any state returns to IDLE with reset values at that edge.

## Timing
- All outputs are registered except imem_we/imem_addr/imem_wdata. Those are combinational: imem_we = ld_valid&ld_ready, imem_wdata = ld_data, imem_addr = current address register.
- start at edge t → ld_ready=1 from t+1. One word accepted per cycle max.
- ld_last handshake at edge t → core_rst=0 from t+1. core_pc_en=1 from t+1+RELEASE_DLY.
- halt_in sampled at edge t → core_pc_en=0 and done=1 from t+1. The halting instruction's cycle is counted.
- Step pulse high at edge t (state RUN) → core_pc_en=1 during cycle t+1 only, per high cycle.

## Structure
- The shared package holds the state encoding (IDLE=0 … DONE=4) and the default parameter constants.
- One sub-module, `run_counter`: a CNT_W saturating counter with clear/enable/terminal-compare. It is used for both the RELEASE delay and cycle_cnt.

## Test plan
- Load 4 words 0x00500093,0x00300113,0x002081B3,0x00000073 with ld_last on word 4 → addresses 0..3 written, core_rst falls the cycle after, core_pc_en rises 2 cycles later (RELEASE_DLY=2).
- Free-run; halt_in asserted on the 4th pc_en cycle → done=1 next cycle, cycle_cnt=4, timed_out=0, core_pc_en=0.
- TIMEOUT=10, halt never asserted → exactly 10 pc_en cycles, done=1, timed_out=1; halt and timeout coincident → timed_out=0.
- IMEM_AW=2, 5 words without ld_last → words 0..3 written, load_ovf=1, the 5th word is not accepted (ld_ready=0 after transition).
- step_mode=1, step pulsed on 3 non-adjacent cycles → exactly 3 single-cycle core_pc_en pulses, cycle_cnt=3.
- rst=0 mid-RUN → next cycle core_rst=1, core_pc_en=0, all status 0; start from DONE restarts load at address 0.
